// File: rtl/avalon_mem_responder.sv
// rtl/avalon_mem_responder.sv - Avalon-MM memory responder with fixed read latency, pending limit and stall injection
module avalon_mem_responder #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4,
    parameter int WAIT_PERIOD  = 0
) (
    input  logic        iClk,
    input  logic        iRstn,
    input  logic [31:0] iAddress_Read,
    input  logic        iRead,
    output logic [31:0] oReadData,
    output logic        oDataValid,
    output logic        oWait_Read,
    input  logic [31:0] iAddress_Write,
    input  logic [31:0] iData_Write,
    input  logic        iWrite,
    output logic        oWait_Write
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SW    = (WAIT_PERIOD >= 2) ? $clog2(WAIT_PERIOD) : 1;
    localparam logic [SW-1:0] STALL_LAST = (WAIT_PERIOD >= 2) ? SW'(WAIT_PERIOD - 1) : '0;
    localparam logic          STALL_EN   = (WAIT_PERIOD >= 2);
    localparam logic [3:0]    PEND_MAX   = 4'(MAX_PENDING);

    logic [31:0]             mem_q [DEPTH];
    logic [ADDR_W-1:0]       rd_idx;
    logic [ADDR_W-1:0]       wr_idx;
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    stall;
    logic [SW-1:0]           stall_cnt_q, stall_cnt_d;
    logic [3:0]              pending_q, pending_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             dat_q [READ_LATENCY];
    logic [31:0]             dat_d [READ_LATENCY];
    logic                    unused_addr_bits;

    assign rd_idx = iAddress_Read[ADDR_W+1:2];
    assign wr_idx = iAddress_Write[ADDR_W+1:2];
    assign unused_addr_bits = ^{iAddress_Read[31:ADDR_W+2], iAddress_Read[1:0],
                                iAddress_Write[31:ADDR_W+2], iAddress_Write[1:0]};

    // Waits come from registered state only; a retiring read frees its slot this cycle.
    always_comb begin
        stall       = STALL_EN && (stall_cnt_q == STALL_LAST);
        oDataValid  = vld_q[READ_LATENCY-1];
        oReadData   = dat_q[READ_LATENCY-1];
        oWait_Write = stall;
        oWait_Read  = stall || ((pending_q == PEND_MAX) && !oDataValid);
        rd_acc      = iRead && !oWait_Read;
        wr_acc      = iWrite && !oWait_Write && iRstn;
    end

    always_comb begin
        stall_cnt_d = '0;
        if (STALL_EN && (stall_cnt_q != STALL_LAST)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        pending_d = pending_q;
        case ({rd_acc, oDataValid})
            2'b10:   pending_d = pending_q + 4'd1;
            2'b01:   pending_d = pending_q - 4'd1;
            default: pending_d = pending_q;
        endcase

        // Data advances only behind a valid bit so the output stage holds between returns.
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = rd_acc;
        if (rd_acc) begin
            dat_d[0] = mem_q[rd_idx];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            stall_cnt_q <= '0;
            pending_q   <= '0;
            vld_q       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            pending_q   <= pending_d;
            vld_q       <= vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Contents are deliberately not reset; the read port samples the pre-write value at a shared edge.
    always_ff @(posedge iClk) begin
        if (wr_acc) begin
            mem_q[wr_idx] <= iData_Write;
        end
    end

endmodule
